ffe_mac_engine: RTL and testbench



---
 rtl/ffe_pkg.sv | 14 +
 rtl/ffe_round_sat.sv | 11 +
 rtl/ffe_mac_engine.sv | 77 +++++++
 tb/tb_ffe_mac_engine.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ffe_pkg.sv
// ffe_pkg: shared FSM encoding, default widths and round/saturate helper for the FFE datapath
package ffe_pkg;
  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;
  localparam int DEF_IO_W = 12;
  localparam int DEF_COEF_W = 12;
  localparam int DEF_DEPTH = 4;
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc, input int frac, input int w);
    logic signed [63:0] r, hi, lo;
    r = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/ffe_round_sat.sv
// ffe_round_sat: round-half-up by FRAC_BITS then clamp i_acc to a signed OUT_WIDTH o_y
module ffe_round_sat import ffe_pkg::*; #(
  parameter int ACC_WIDTH = 26,
  parameter int OUT_WIDTH = 12,
  parameter int FRAC_BITS = 10
) (
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  output logic signed [OUT_WIDTH-1:0] o_y
);
  assign o_y = OUT_WIDTH'(round_sat(64'(i_acc), FRAC_BITS, OUT_WIDTH));
endmodule

// File: rtl/ffe_mac_engine.sv
// ffe_mac_engine: walks DEPTH taps per sample, multiply-accumulates with a coefficient bank, rounds/saturates to y_out
module ffe_mac_engine import ffe_pkg::*; #(
  parameter int IN_OUT_BUS_WIDTH = DEF_IO_W,
  parameter int COEF_WIDTH = DEF_COEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_SIZE = $clog2(DEPTH),
  parameter int FRAC_BITS = 10,
  parameter int ACC_WIDTH = IN_OUT_BUS_WIDTH + COEF_WIDTH + ADDR_SIZE
) (
  input  logic                               ffe_clk,
  input  logic                               rst,
  input  logic                               sample_valid,
  input  logic                               coef_wr_en,
  input  logic [ADDR_SIZE-1:0]               coef_wr_addr,
  input  logic signed [COEF_WIDTH-1:0]       coef_wr_data,
  input  logic signed [IN_OUT_BUS_WIDTH-1:0] rd_data,
  output logic                               rd_en,
  output logic [ADDR_SIZE-1:0]               rd_addr,
  output logic                               shift_en,
  output logic signed [IN_OUT_BUS_WIDTH-1:0] y_out,
  output logic                               y_valid,
  output logic                               busy,
  output logic                               overrun
);
  localparam int PW = IN_OUT_BUS_WIDTH + COEF_WIDTH;
  state_t r_state, w_next;
  logic [ADDR_SIZE-1:0] r_cnt;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [COEF_WIDTH-1:0] r_coef [DEPTH];
  logic signed [IN_OUT_BUS_WIDTH-1:0] r_y, w_y;
  logic r_yv, r_ovr, w_last;
  logic signed [PW-1:0] w_prod;
  assign w_last = r_cnt == ADDR_SIZE'(DEPTH - 1);
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (sample_valid ? MAC : IDLE) :
             r_state == MAC  ? (w_last ? DONE : MAC) : IDLE;
  end
  always_ff @(posedge ffe_clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  assign rd_en = r_state == MAC;
  assign rd_addr = rd_en ? r_cnt : '0;
  assign shift_en = r_state == DONE;
  assign busy = r_state != IDLE;
  assign w_prod = PW'(rd_data) * PW'(r_coef[r_cnt]);
  always_ff @(posedge ffe_clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_y <= '0;
      r_yv <= 1'b0;
      r_ovr <= 1'b0;
      for (int k = 0; k < DEPTH; k++) r_coef[k] <= '0;
    end else begin
      r_yv <= r_state == DONE;
      r_ovr <= sample_valid && busy;
      if (coef_wr_en) r_coef[coef_wr_addr] <= coef_wr_data;
      if (r_state == IDLE && sample_valid) begin
        r_acc <= '0;
        r_cnt <= '0;
      end
      if (r_state == MAC) begin
        r_acc <= r_acc + ACC_WIDTH'(w_prod);
        r_cnt <= w_last ? '0 : r_cnt + ADDR_SIZE'(1);
      end
      if (r_state == DONE) r_y <= w_y;
    end
  end
  ffe_round_sat #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(IN_OUT_BUS_WIDTH), .FRAC_BITS(FRAC_BITS)) u_rs (
    .i_acc(r_acc),
    .o_y(w_y)
  );
  assign y_out = r_y;
  assign y_valid = r_yv;
  assign overrun = r_ovr;
endmodule

// File: tb/tb_ffe_mac_engine.sv
// tb_ffe_mac_engine: randomized and directed checks of ffe_mac_engine against an arithmetic reference
module tb_ffe_mac_engine;
  logic ffe_clk = 1'b0, rst = 1'b1, sample_valid = 1'b0, coef_wr_en = 1'b0;
  logic [1:0] coef_wr_addr = '0;
  logic signed [11:0] coef_wr_data = '0;
  logic signed [11:0] rd_data, y_out;
  logic rd_en, shift_en, y_valid, busy, overrun;
  logic [1:0] rd_addr;
  logic signed [11:0] tap [4];
  int c [4];
  int total = 0, bad = 0;
  always #5 ffe_clk = ~ffe_clk;
  assign rd_data = tap[rd_addr];
  ffe_mac_engine dut (
    .ffe_clk(ffe_clk), .rst(rst), .sample_valid(sample_valid),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .rd_data(rd_data), .rd_en(rd_en), .rd_addr(rd_addr), .shift_en(shift_en),
    .y_out(y_out), .y_valid(y_valid), .busy(busy), .overrun(overrun)
  );
  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint ref_y();
    longint s = 0, n, q;
    for (int i = 0; i < 4; i++) s += longint'(c[i]) * longint'(tap[i]);
    n = s + 512;
    q = n / 1024;
    if (n % 1024 != 0 && n < 0) q--;
    return q > 2047 ? 2047 : q < -2048 ? -2048 : q;
  endfunction
  task automatic wr_coef(input int a, input int v);
    coef_wr_en = 1'b1;
    coef_wr_addr = 2'(a);
    coef_wr_data = 12'(v);
    @(negedge ffe_clk);
    coef_wr_en = 1'b0;
    c[a] = v;
  endtask
  task automatic set_taps(input int a, input int b, input int d, input int e);
    tap[0] = 12'(a); tap[1] = 12'(b); tap[2] = 12'(d); tap[3] = 12'(e);
  endtask
  task automatic do_sample(input string tag, input int ovr, input int wi, input int wv);
    longint e = ref_y();
    sample_valid = 1'b1;
    @(negedge ffe_clk);
    sample_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == ovr) sample_valid = 1'b1;
      if (ovr >= 0 && i == ovr + 1) begin
        sample_valid = 1'b0;
        chk({tag, "_ovr1"}, overrun, 1);
      end else chk({tag, "_ovr0"}, overrun, 0);
      if (i == wi) begin
        coef_wr_en = 1'b1;
        coef_wr_addr = 2'(wi);
        coef_wr_data = 12'(wv);
      end else coef_wr_en = 1'b0;
      chk({tag, "_rden"}, rd_en, 1);
      chk({tag, "_addr"}, rd_addr, i);
      chk({tag, "_shift0"}, shift_en, 0);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_yv0"}, y_valid, 0);
      @(negedge ffe_clk);
    end
    coef_wr_en = 1'b0;
    if (wi >= 0) c[wi] = wv;
    chk({tag, "_shift1"}, shift_en, 1);
    chk({tag, "_rden0"}, rd_en, 0);
    chk({tag, "_yvd"}, y_valid, 0);
    chk({tag, "_ovrd"}, overrun, ovr == 3 ? 1 : 0);
    @(negedge ffe_clk);
    chk({tag, "_yv1"}, y_valid, 1);
    chk({tag, "_yout"}, y_out, e);
    chk({tag, "_shiftend"}, shift_en, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) c[i] = 0;
    set_taps(55, -9, 300, 1);
    sample_valid = 1'b1;
    @(negedge ffe_clk);
    @(negedge ffe_clk);
    chk("rst_yout", y_out, 0);
    chk("rst_yv", y_valid, 0);
    chk("rst_rden", rd_en, 0);
    chk("rst_shift", shift_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_addr", rd_addr, 0);
    rst = 1'b0;
    sample_valid = 1'b0;
    @(negedge ffe_clk);
    chk("post_rst_busy", busy, 0);
    do_sample("zero_coef", -1, -1, 0);
    for (int i = 0; i < 4; i++) wr_coef(i, i == 0 ? 1024 : 0);
    set_taps(100, 7, 7, 7);
    do_sample("ident", -1, -1, 0);
    repeat (3) @(negedge ffe_clk);
    chk("hold_yout", y_out, 100);
    chk("hold_yv", y_valid, 0);
    for (int i = 0; i < 4; i++) wr_coef(i, 1024);
    set_taps(1000, 1000, 1000, 1000);
    do_sample("sat_hi", -1, -1, 0);
    set_taps(-1000, -1000, -1000, -1000);
    do_sample("sat_lo", -1, -1, 0);
    wr_coef(0, 512);
    for (int i = 1; i < 4; i++) wr_coef(i, 0);
    set_taps(3, 50, 50, 50);
    do_sample("rnd_p3", -1, -1, 0);
    tap[0] = -12'sd3;
    do_sample("rnd_m3", -1, -1, 0);
    tap[0] = 12'sd1;
    do_sample("rnd_p1", -1, -1, 0);
    for (int i = 0; i < 4; i++) wr_coef(i, 256 * (i + 1));
    set_taps(40, -80, 120, -160);
    do_sample("ovr", 1, -1, 0);
    do_sample("ovr_next", -1, -1, 0);
    do_sample("cw_mid", -1, 2, -700);
    do_sample("cw_after", -1, -1, 0);
    sample_valid = 1'b1;
    @(negedge ffe_clk);
    sample_valid = 1'b0;
    @(negedge ffe_clk);
    rst = 1'b1;
    @(negedge ffe_clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_rden", rd_en, 0);
    chk("abort_shift", shift_en, 0);
    for (int i = 0; i < 4; i++) c[i] = 0;
    for (int k = 0; k < 4; k++) begin
      chk("abort_yv", y_valid, 0);
      chk("abort_noshift", shift_en, 0);
      @(negedge ffe_clk);
    end
    set_taps(900, -900, 1500, -2000);
    do_sample("abort_zero", -1, -1, 0);
    for (int n = 0; n < 30; n++) begin
      int m = $urandom_range(1) ? 2047 : 96;
      for (int i = 0; i < 4; i++) wr_coef(i, int'($urandom_range(2 * m)) - m);
      for (int i = 0; i < 4; i++) tap[i] = 12'($urandom_range(4095));
      do_sample("rand", $urandom_range(3) == 0 ? int'($urandom_range(2)) : -1,
                $urandom_range(3) == 0 ? int'($urandom_range(3)) : -1, int'($urandom_range(4095)) - 2048);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
